nn_eval_sequencer: RTL and testbench

NN_EVAL_SEQUENCER -- requirements
Module: nn_eval_sequencer

---
 rtl/nn_eval_sequencer.sv | 168 ++++++++++++++++
 tb/tb_nn_eval_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/nn_eval_sequencer.sv
// Sequencer for a two-layer fixed-point threshold network.
// It streams weights from an external memory and evaluates one neuron at a time.
module nn_eval_sequencer #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned INPUT_SIZE  = 4,
  parameter int unsigned HIDDEN_SIZE = 4,
  parameter int unsigned OUTPUT_SIZE = 2,
  parameter int unsigned ADDR_WIDTH  = 8
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               start,
  input  logic [DATA_WIDTH*INPUT_SIZE-1:0]   input_data,
  output logic                               weight_rd_en,
  output logic [ADDR_WIDTH-1:0]              weight_addr,
  input  logic [DATA_WIDTH-1:0]              weight_data,
  output logic                               busy,
  output logic                               done,
  output logic [DATA_WIDTH*OUTPUT_SIZE-1:0]  output_data
);

  localparam int unsigned FRAC      = DATA_WIDTH / 2;
  localparam int unsigned HID_WORDS = HIDDEN_SIZE * (INPUT_SIZE + 1);
  localparam int unsigned TOTAL     = HID_WORDS + OUTPUT_SIZE * (HIDDEN_SIZE + 1);
  localparam int unsigned MAX_FAN   = (INPUT_SIZE > HIDDEN_SIZE) ? INPUT_SIZE : HIDDEN_SIZE;
  localparam int unsigned EW        = $clog2(MAX_FAN + 1);
  localparam int unsigned MAX_N     = (HIDDEN_SIZE > OUTPUT_SIZE) ? HIDDEN_SIZE : OUTPUT_SIZE;
  localparam int unsigned NW        = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1) << FRAC;

  typedef enum logic [1:0] {StIdle, StHidden, StOutput, StDrain} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    word_valid_q;
  logic [DATA_WIDTH-1:0]   x_q   [INPUT_SIZE];
  logic [DATA_WIDTH-1:0]   hid_q [HIDDEN_SIZE];
  logic [DATA_WIDTH-1:0]   acc_q;
  logic [EW-1:0]           elem_q;
  logic [NW-1:0]           neuron_q;
  logic                    layer_q;
  logic                    done_q;
  logic [DATA_WIDTH*OUTPUT_SIZE-1:0] out_q;

  logic [DATA_WIDTH-1:0]   x_sel;
  logic [2*DATA_WIDTH-1:0] prod_full;
  logic [DATA_WIDTH-1:0]   prod;
  logic [DATA_WIDTH-1:0]   result;
  logic                    is_thr;
  logic                    neuron_last;
  logic                    last_word;
  logic                    accept;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StHidden;
      StHidden: if (addr_q == ADDR_WIDTH'(HID_WORDS - 1)) state_d = StOutput;
      StOutput: if (addr_q == ADDR_WIDTH'(TOTAL - 1)) state_d = StDrain;
      StDrain:  if (last_word) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    weight_rd_en = (state_q == StHidden) || (state_q == StOutput);
    weight_addr  = weight_rd_en ? addr_q : '0;
    busy         = (state_q != StIdle);
  end

  assign done        = done_q;
  assign output_data = out_q;
  assign accept      = (state_q == StIdle) && start;

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      // Read data lands one cycle after the strobe, so a delayed strobe marks it valid.
      word_valid_q <= weight_rd_en;
      if (state_q == StIdle) begin
        addr_q <= '0;
      end else if (weight_rd_en) begin
        addr_q <= addr_q + 1'b1;
      end
    end
  end

  // Operand select and fixed-point product
  always_comb begin
    x_sel = '0;
    if (!layer_q) begin
      for (int i = 0; i < INPUT_SIZE; i++) begin
        if (elem_q == EW'(i)) x_sel = x_q[i];
      end
    end else begin
      for (int i = 0; i < HIDDEN_SIZE; i++) begin
        if (elem_q == EW'(i)) x_sel = hid_q[i];
      end
    end
    prod_full   = {{DATA_WIDTH{1'b0}}, x_sel} * {{DATA_WIDTH{1'b0}}, weight_data};
    prod        = DATA_WIDTH'(prod_full >> FRAC);
    result      = (acc_q >= weight_data) ? ONE : '0;
    is_thr      = layer_q ? (elem_q == EW'(HIDDEN_SIZE)) : (elem_q == EW'(INPUT_SIZE));
    neuron_last = layer_q ? (neuron_q == NW'(OUTPUT_SIZE - 1))
                          : (neuron_q == NW'(HIDDEN_SIZE - 1));
    last_word   = word_valid_q && layer_q && is_thr && neuron_last;
  end

  // Datapath: consume one returned word per cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < INPUT_SIZE; i++) x_q[i] <= '0;
      for (int j = 0; j < HIDDEN_SIZE; j++) hid_q[j] <= '0;
      acc_q    <= '0;
      elem_q   <= '0;
      neuron_q <= '0;
      layer_q  <= 1'b0;
      done_q   <= 1'b0;
      out_q    <= '0;
    end else begin
      done_q <= last_word;
      if (accept) begin
        for (int i = 0; i < INPUT_SIZE; i++) x_q[i] <= input_data[i*DATA_WIDTH +: DATA_WIDTH];
        acc_q    <= '0;
        elem_q   <= '0;
        neuron_q <= '0;
        layer_q  <= 1'b0;
      end else if (word_valid_q) begin
        if (is_thr) begin
          acc_q  <= '0;
          elem_q <= '0;
          if (!layer_q) begin
            for (int j = 0; j < HIDDEN_SIZE; j++) begin
              if (neuron_q == NW'(j)) hid_q[j] <= result;
            end
          end else begin
            for (int k = 0; k < OUTPUT_SIZE; k++) begin
              if (neuron_q == NW'(k)) out_q[k*DATA_WIDTH +: DATA_WIDTH] <= result;
            end
          end
          if (neuron_last) begin
            neuron_q <= '0;
            layer_q  <= ~layer_q;
          end else begin
            neuron_q <= neuron_q + 1'b1;
          end
        end else begin
          acc_q  <= acc_q + prod;
          elem_q <= elem_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nn_eval_sequencer.sv
// Directed bench for nn_eval_sequencer with a 2-2-1 network (TOTAL = 9).
// A behavioural memory returns mem[addr] one cycle after each read strobe.
module tb_nn_eval_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] input_data = 32'h0;
  logic        weight_rd_en;
  logic [7:0]  weight_addr;
  logic [15:0] weight_data = 16'h0;
  logic        busy;
  logic        done;
  logic [15:0] output_data;

  logic [15:0] mem [0:255];
  int checks = 0;
  int errors = 0;

  nn_eval_sequencer #(
    .DATA_WIDTH (16),
    .INPUT_SIZE (2),
    .HIDDEN_SIZE(2),
    .OUTPUT_SIZE(1),
    .ADDR_WIDTH (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .input_data  (input_data),
    .weight_rd_en(weight_rd_en),
    .weight_addr (weight_addr),
    .weight_data (weight_data),
    .busy        (busy),
    .done        (done),
    .output_data (output_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    weight_data <= weight_rd_en ? mem[weight_addr] : 16'hDEAD;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [15:0] h0a, input logic [15:0] h0b, input logic [15:0] h0t,
                      input logic [15:0] h1a, input logic [15:0] h1b, input logic [15:0] h1t,
                      input logic [15:0] oa, input logic [15:0] ob, input logic [15:0] ot);
    mem[0] = h0a; mem[1] = h0b; mem[2] = h0t;
    mem[3] = h1a; mem[4] = h1b; mem[5] = h1t;
    mem[6] = oa;  mem[7] = ob;  mem[8] = ot;
  endtask

  // Starts a run from a negedge; cycle k follows the k-th rising edge after the start edge.
  // pulse_at=11 restarts in the done cycle; reset_at>0 aborts the run.
  task automatic run(input int ncyc, input int pulse_at, input int reset_at,
                     input logic [15:0] exp_out);
    int  r;
    bit  aborted;
    bit  exp_rd, exp_busy, exp_done;
    logic [7:0] exp_addr;
    start = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clock);
      aborted = (reset_at > 0) && (k > reset_at);
      r = (pulse_at == 11 && k >= 12) ? k - 11 : k;
      exp_rd   = !aborted && r >= 1 && r <= 9;
      exp_addr = exp_rd ? 8'(r - 1) : 8'd0;
      exp_busy = !aborted && r >= 1 && r <= 10;
      exp_done = !aborted && r == 11;
      check($sformatf("rd_en@%0d", k), 32'(weight_rd_en), 32'(exp_rd));
      check($sformatf("addr@%0d", k), 32'(weight_addr), 32'(exp_addr));
      check($sformatf("busy@%0d", k), 32'(busy), 32'(exp_busy));
      check($sformatf("done@%0d", k), 32'(done), 32'(exp_done));
      if (exp_done) check($sformatf("out@%0d", k), 32'(output_data), 32'(exp_out));
      if (aborted && k == reset_at + 1)
        check($sformatf("out_after_reset@%0d", k), 32'(output_data), 32'h0);
      start = (k == pulse_at);
      reset = (k == reset_at);
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    repeat (3) @(negedge clock);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_rd_en", 32'(weight_rd_en), 32'h0);
    check("reset_addr", 32'(weight_addr), 32'h0);
    check("reset_out", 32'(output_data), 32'h0);
    reset = 1'b0;
    @(negedge clock);

    // Basic evaluation: hidden = {1.0, 0}, output acc 0x0100 >= 0x0100.
    input_data = {16'h0200, 16'h0100};
    load(16'h0080, 16'h0080, 16'h0180, 16'h0040, 16'h0040, 16'h0100,
         16'h0100, 16'h0100, 16'h0100);
    run(12, 0, 0, 16'h0100);

    // Output threshold just above the accumulator.
    mem[8] = 16'h0101;
    run(12, 0, 0, 16'h0000);

    // Hidden0 accumulator wraps to 0 and misses threshold 1.
    input_data = {16'h0100, 16'h0100};
    load(16'h8000, 16'h8000, 16'h0001, 16'h0000, 16'h0000, 16'hFFFF,
         16'h0100, 16'h0100, 16'h0001);
    run(12, 0, 0, 16'h0000);

    // Start during busy is ignored; start in the done cycle is accepted.
    input_data = {16'h0200, 16'h0100};
    load(16'h0080, 16'h0080, 16'h0180, 16'h0040, 16'h0040, 16'h0100,
         16'h0100, 16'h0100, 16'h0100);
    run(12, 5, 0, 16'h0100);
    run(23, 11, 0, 16'h0100);

    // Reset mid-run aborts cleanly, then a fresh run still evaluates correctly.
    run(12, 0, 6, 16'h0100);
    run(12, 0, 0, 16'h0100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
